input_controller: RTL and testbench

INPUT_CONTROLLER -- requirements
Module: input_controller

---
 rtl/input_controller.sv | 170 +++++++++++++++++
 tb/tb_input_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_controller.sv
// Button front end: synchronise, debounce and decode seven active-low keys into
// gameplay hold levels, press pulses and a rate-limited attack pulse.
module input_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned ATTACK_COOLDOWN = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] i_key_n,
   input  logic       i_is_gaming,
   output logic       right,
   output logic       left,
   output logic       jump,
   output logic       squat,
   output logic       attack,
   output logic       defend,
   output logic       select,
   output logic       o_cooldown
);

   localparam int          NK      = 7;
   localparam int unsigned CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned AW      = $clog2(ATTACK_COOLDOWN + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW-1:0] CD_LOAD = AW'(ATTACK_COOLDOWN);

   localparam int K_RIGHT  = 0;
   localparam int K_LEFT   = 1;
   localparam int K_JUMP   = 2;
   localparam int K_SQUAT  = 3;
   localparam int K_ATTACK = 4;
   localparam int K_DEFEND = 5;
   localparam int K_SELECT = 6;

   typedef enum logic {A_READY, A_COOL} a_state_t;

   logic [NK-1:0] sync1, sync2, s;
   logic [NK-1:0] db, db_d, armed;
   logic [CW-1:0] db_cnt [NK];
   logic [1:0]    fill;
   logic [NK-1:0] rise_c;

   a_state_t      state, state_next;
   logic [AW-1:0] cool_cnt, cool_next;
   logic          attack_fire_c, cool_active_c;

   // Two-flop synchroniser; reset value is "released"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= i_key_n;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   // Per-key debounce: toggle after DEBOUNCE_CYCLES consecutive mismatches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int k = 0; k < NK; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (s[k] == db[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               db[k]     <= ~db[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + CW'(1);
            end
         end
      end
   end

   // A key may only pulse once it has been seen released after the
   // synchroniser has filled, so keys held through reset stay silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill  <= '0;
         armed <= '0;
         db_d  <= '0;
      end else begin
         if (fill != 2'd2) fill <= fill + 2'd1;
         armed <= armed | ({NK{fill == 2'd2}} & ~s);
         db_d  <= db;
      end
   end

   assign rise_c = db & ~db_d & armed;

   // Attack FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= A_READY;
         cool_cnt <= '0;
      end else begin
         state    <= state_next;
         cool_cnt <= cool_next;
      end
   end

   // Attack FSM: next state
   always_comb begin
      state_next = state;
      cool_next  = cool_cnt;
      if (!i_is_gaming) begin
         state_next = A_READY;
         cool_next  = '0;
      end else begin
         case (state)
            A_READY: begin
               if (rise_c[K_ATTACK]) begin
                  state_next = A_COOL;
                  cool_next  = CD_LOAD;
               end
            end
            A_COOL: begin
               if (cool_cnt <= AW'(1)) begin
                  state_next = A_READY;
                  cool_next  = '0;
               end else begin
                  cool_next = cool_cnt - AW'(1);
               end
            end
            default: begin
               state_next = A_READY;
               cool_next  = '0;
            end
         endcase
      end
   end

   // Attack FSM: outputs
   always_comb begin
      attack_fire_c = 1'b0;
      cool_active_c = 1'b0;
      if (i_is_gaming) begin
         attack_fire_c = (state == A_READY) && rise_c[K_ATTACK];
         cool_active_c = (state == A_COOL);
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         right      <= 1'b0;
         left       <= 1'b0;
         jump       <= 1'b0;
         squat      <= 1'b0;
         attack     <= 1'b0;
         defend     <= 1'b0;
         select     <= 1'b0;
         o_cooldown <= 1'b0;
      end else begin
         right      <= db[K_RIGHT] & ~db[K_LEFT] & i_is_gaming;
         left       <= db[K_LEFT] & ~db[K_RIGHT] & i_is_gaming;
         squat      <= db[K_SQUAT] & i_is_gaming;
         defend     <= db[K_DEFEND] & i_is_gaming;
         jump       <= rise_c[K_JUMP] & ~db[K_SQUAT] & i_is_gaming;
         select     <= rise_c[K_SELECT];
         attack     <= attack_fire_c;
         o_cooldown <= cool_active_c;
      end
   end

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with DEBOUNCE_CYCLES=4, ATTACK_COOLDOWN=10
// (key-to-output latency 7 cycles).
module tb_input_controller;

   localparam int unsigned DB = 4;
   localparam int unsigned CD = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] key_n;
   logic       gaming;
   logic       right, left, jump, squat, attack, defend, select, o_cooldown;
   logic [7:0] outs;

   int vectors = 0;
   int errors  = 0;

   input_controller #(.DEBOUNCE_CYCLES(DB), .ATTACK_COOLDOWN(CD)) dut (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_n), .i_is_gaming(gaming),
      .right(right), .left(left), .jump(jump), .squat(squat),
      .attack(attack), .defend(defend), .select(select), .o_cooldown(o_cooldown)
   );

   always #5 clk = ~clk;

   assign outs = {o_cooldown, select, defend, attack, squat, jump, left, right};

   task automatic do_reset();
      rst_n  = 1'b0;
      key_n  = '1;
      gaming = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      key_n  = '0;
      gaming = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset c=%0d got %b want %b", c, outs, 8'h00);
         end
      end
   endtask

   // Right held 0..19 -> high 7..26
   task automatic test_right_hold();
      logic [1:0] exp;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         key_n = (c < 20) ? 7'b111_1110 : 7'b111_1111;
         exp = {1'b0, (c >= 7 && c < 27)};
         vectors++;
         if ({left, right} !== exp) begin
            errors++;
            $display("FAIL right_hold c=%0d got %b want %b", c, {left, right}, exp);
         end
      end
   endtask

   // 3-cycle glitch ignored; 10-cycle press at 20 -> one pulse at 27
   task automatic test_jump_glitch();
      logic exp;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         key_n = ((c < 3) || (c >= 20 && c < 30)) ? 7'b111_1011 : 7'b111_1111;
         exp = (c == 27);
         vectors++;
         if (jump !== exp) begin
            errors++;
            $display("FAIL jump_glitch c=%0d got %b want %b", c, jump, exp);
         end
      end
   endtask

   // Squat held suppresses jump press
   task automatic test_squat_blocks_jump();
      logic [1:0] exp;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         key_n = (c >= 10 && c < 20) ? 7'b111_0011 : 7'b111_0111;
         exp = {(c >= 7), 1'b0};
         vectors++;
         if ({squat, jump} !== exp) begin
            errors++;
            $display("FAIL squat_jump c=%0d got %b want %b", c, {squat, jump}, exp);
         end
      end
   endtask

   // Right+left held cancel; left released at 15 -> right at 22
   task automatic test_both_dirs();
      logic [1:0] exp;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         key_n = (c < 15) ? 7'b111_1100 : 7'b111_1110;
         exp = {1'b0, (c >= 22)};
         vectors++;
         if ({left, right} !== exp) begin
            errors++;
            $display("FAIL both_dirs c=%0d got %b want %b", c, {left, right}, exp);
         end
      end
   endtask

   // Attack presses at 0, 9 (inside cooldown), 30; each held 5 cycles
   task automatic test_attack_cooldown();
      logic [1:0] exp;
      logic       pr;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 52; c++) begin
         @(negedge clk);
         pr = (c < 5) || (c >= 9 && c < 14) || (c >= 30 && c < 35);
         key_n = pr ? 7'b110_1111 : 7'b111_1111;
         exp = {((c >= 8 && c <= 17) || (c >= 38 && c <= 47)), (c == 7 || c == 37)};
         vectors++;
         if ({o_cooldown, attack} !== exp) begin
            errors++;
            $display("FAIL attack_cd c=%0d got %b want %b", c, {o_cooldown, attack}, exp);
         end
      end
   endtask

   // Not gaming: every key pressed, only select pulses
   task automatic test_not_gaming();
      logic [7:0] exp;
      do_reset();
      gaming = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         key_n = (c < 10) ? 7'b000_0000 : 7'b111_1111;
         exp = (c == 7) ? 8'b0100_0000 : 8'h00;
         vectors++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL not_gaming c=%0d got %b want %b", c, outs, exp);
         end
      end
   endtask

   // Dropping gaming at cycle 12 ends cooldown at 13
   task automatic test_gaming_drop();
      logic [1:0] exp;
      do_reset();
      gaming = 1'b1;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         key_n = (c < 5) ? 7'b110_1111 : 7'b111_1111;
         if (c == 12) gaming = 1'b0;
         exp = {(c >= 8 && c <= 12), (c == 7)};
         vectors++;
         if ({o_cooldown, attack} !== exp) begin
            errors++;
            $display("FAIL gaming_drop c=%0d got %b want %b", c, {o_cooldown, attack}, exp);
         end
      end
   endtask

   // Keys held when gaming rises: levels follow, no jump pulse
   task automatic test_gaming_rise();
      logic [1:0] exp;
      do_reset();
      gaming = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         key_n = 7'b101_1011;
         if (c == 15) gaming = 1'b1;
         exp = {(c >= 16), 1'b0};
         vectors++;
         if ({defend, jump} !== exp) begin
            errors++;
            $display("FAIL gaming_rise c=%0d got %b want %b", c, {defend, jump}, exp);
         end
      end
   endtask

   // Reset during cooldown with attack held; pulse only after re-press
   task automatic test_reset_mid();
      do_reset();
      gaming = 1'b1;
      key_n  = 7'b110_1111;
      repeat (10) @(negedge clk);
      vectors++;
      if ({o_cooldown, attack} !== 2'b10) begin
         errors++;
         $display("FAIL pre_reset got %b want %b", {o_cooldown, attack}, 2'b10);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (outs !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got %b want %b", outs, 8'h00);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 46; c++) begin
         if (c > 0) @(negedge clk);
         key_n = (c < 20 || (c >= 30 && c < 40)) ? 7'b110_1111 : 7'b111_1111;
         vectors++;
         if (attack !== (c == 37)) begin
            errors++;
            $display("FAIL reset_hold c=%0d got %b want %b", c, attack, (c == 37));
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      key_n  = '1;
      gaming = 1'b0;
      test_reset();
      test_right_hold();
      test_jump_glitch();
      test_squat_blocks_jump();
      test_both_dirs();
      test_attack_cooldown();
      test_not_gaming();
      test_gaming_drop();
      test_gaming_rise();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
